// File: rtl/uart_param.sv
// uart_param: full-duplex UART with a shared baud-tick generator, a valid/ready transmitter and an oversampling receiver.
// Define UART_PARITY_EN to add a parity bit to both directions. Without it, parity_odd is ignored and rx_parity_err stays 0.
module uart_param #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              stop2,
  input  logic              parity_odd,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              serial_out,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_parity_err
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVS - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] ZERO_TICK = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_TICK  = CW'(1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

`ifdef UART_PARITY_EN
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_odd;
`endif

  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;

  assign tick_s = (div_cnt_r >= divisor);

  // Baud tick counter; the >= compare wraps at once when divisor shrinks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  tx_state_t         tx_state_r, tx_state_nxt;
  logic [CW-1:0]     tx_tick_r, tx_tick_nxt;
  logic [3:0]        tx_bit_r, tx_bit_nxt;
  logic [DATA_W-1:0] tx_shift_r, tx_shift_nxt;
  logic              tx_stop2_r, tx_stop2_nxt;
  logic              tx_stop_cnt_r, tx_stop_cnt_nxt;
  logic              serial_out_r, serial_out_nxt;
  logic              tx_ready_r, tx_ready_nxt;
  logic              tx_bit_done_s;
`ifdef UART_PARITY_EN
  logic              tx_par_r, tx_par_nxt;
`endif

  assign tx_bit_done_s = tick_s && (tx_tick_r == LAST_TICK);

  // TX next-state, shifter and line value
  always_comb begin
    tx_state_nxt    = tx_state_r;
    tx_bit_nxt      = tx_bit_r;
    tx_shift_nxt    = tx_shift_r;
    tx_stop2_nxt    = tx_stop2_r;
    tx_stop_cnt_nxt = tx_stop_cnt_r;
    serial_out_nxt  = serial_out_r;
`ifdef UART_PARITY_EN
    tx_par_nxt      = tx_par_r;
`endif
    if (tx_state_r == TX_IDLE) begin
      tx_tick_nxt = ZERO_TICK;
    end else if (tx_bit_done_s) begin
      tx_tick_nxt = ZERO_TICK;
    end else if (tick_s) begin
      tx_tick_nxt = tx_tick_r + ONE_TICK;
    end else begin
      tx_tick_nxt = tx_tick_r;
    end
    case (tx_state_r)
      TX_IDLE: begin
        serial_out_nxt = 1'b1;
        if (tx_valid && tx_ready_r) begin
          tx_state_nxt    = TX_START;
          tx_bit_nxt      = 4'd0;
          tx_shift_nxt    = tx_data;
          tx_stop2_nxt    = stop2;
          tx_stop_cnt_nxt = 1'b0;
          serial_out_nxt  = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_nxt      = parity_bit(tx_data, parity_odd);
`endif
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_bit_done_s) begin
          tx_state_nxt   = TX_DATA;
          serial_out_nxt = tx_shift_r[0];
        end else begin
          tx_state_nxt = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_bit_done_s && (tx_bit_r == LAST_BIT)) begin
`ifdef UART_PARITY_EN
          tx_state_nxt   = TX_PARITY;
          serial_out_nxt = tx_par_r;
`else
          tx_state_nxt   = TX_STOP;
          serial_out_nxt = 1'b1;
`endif
        end else if (tx_bit_done_s) begin
          tx_bit_nxt     = tx_bit_r + 4'd1;
          tx_shift_nxt   = tx_shift_r >> 1;
          serial_out_nxt = tx_shift_r[1];
        end else begin
          tx_state_nxt = TX_DATA;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_done_s) begin
          tx_state_nxt   = TX_STOP;
          serial_out_nxt = 1'b1;
        end else begin
          tx_state_nxt = TX_PARITY;
        end
      end
`endif
      TX_STOP: begin
        serial_out_nxt = 1'b1;
        if (tx_bit_done_s && tx_stop2_r && !tx_stop_cnt_r) begin
          tx_stop_cnt_nxt = 1'b1;
        end else if (tx_bit_done_s) begin
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_state_nxt = TX_STOP;
        end
      end
      default: begin
        tx_state_nxt   = TX_IDLE;
        serial_out_nxt = 1'b1;
      end
    endcase
    tx_ready_nxt = (tx_state_nxt == TX_IDLE);
  end

  // TX state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r    <= TX_IDLE;
      tx_tick_r     <= ZERO_TICK;
      tx_bit_r      <= 4'd0;
      tx_shift_r    <= {DATA_W{1'b0}};
      tx_stop2_r    <= 1'b0;
      tx_stop_cnt_r <= 1'b0;
      serial_out_r  <= 1'b1;
      tx_ready_r    <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_r      <= 1'b0;
`endif
    end else begin
      tx_state_r    <= tx_state_nxt;
      tx_tick_r     <= tx_tick_nxt;
      tx_bit_r      <= tx_bit_nxt;
      tx_shift_r    <= tx_shift_nxt;
      tx_stop2_r    <= tx_stop2_nxt;
      tx_stop_cnt_r <= tx_stop_cnt_nxt;
      serial_out_r  <= serial_out_nxt;
      tx_ready_r    <= tx_ready_nxt;
`ifdef UART_PARITY_EN
      tx_par_r      <= tx_par_nxt;
`endif
    end
  end

  assign serial_out = serial_out_r;
  assign tx_ready   = tx_ready_r;

  logic [1:0]        sync_r;
  logic              rx_line_s;
  rx_state_t         rx_state_r, rx_state_nxt;
  logic [CW-1:0]     rx_tick_r, rx_tick_nxt;
  logic [3:0]        rx_bit_r, rx_bit_nxt;
  logic [DATA_W-1:0] rx_shift_r, rx_shift_nxt;
  logic [DATA_W-1:0] rx_data_r, rx_data_nxt;
  logic              rx_valid_r, rx_valid_nxt;
  logic              rx_frame_err_r, rx_frame_err_nxt;
  logic              rx_parity_err_r, rx_parity_err_nxt;
  logic              rx_sample_s;
`ifdef UART_PARITY_EN
  logic              rx_par_bad_r, rx_par_bad_nxt;
`endif

  // Two-flop synchroniser on the asynchronous line, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], serial_in};
    end
  end

  assign rx_line_s   = sync_r[1];
  assign rx_sample_s = tick_s &&
                       (rx_tick_r == ((rx_state_r == RX_START) ? HALF_TICK : LAST_TICK));

  // RX next-state, sampling and one-cycle result pulses
  always_comb begin
    rx_state_nxt      = rx_state_r;
    rx_bit_nxt        = rx_bit_r;
    rx_shift_nxt      = rx_shift_r;
    rx_data_nxt       = rx_data_r;
    rx_valid_nxt      = 1'b0;
    rx_frame_err_nxt  = 1'b0;
    rx_parity_err_nxt = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_nxt    = rx_par_bad_r;
`endif
    if ((rx_state_r == RX_IDLE) || (rx_state_r == RX_BREAK)) begin
      rx_tick_nxt = ZERO_TICK;
    end else if (rx_sample_s) begin
      rx_tick_nxt = ZERO_TICK;
    end else if (tick_s) begin
      rx_tick_nxt = rx_tick_r + ONE_TICK;
    end else begin
      rx_tick_nxt = rx_tick_r;
    end
    case (rx_state_r)
      RX_IDLE: begin
        if (tick_s && !rx_line_s) begin
          rx_state_nxt = RX_START;
        end else begin
          rx_state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_sample_s && !rx_line_s) begin
          rx_state_nxt = RX_DATA;
          rx_bit_nxt   = 4'd0;
        end else if (rx_sample_s) begin
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_sample_s) begin
          rx_shift_nxt = {rx_line_s, rx_shift_r[DATA_W-1:1]};
          rx_bit_nxt   = rx_bit_r + 4'd1;
`ifdef UART_PARITY_EN
          rx_state_nxt = (rx_bit_r == LAST_BIT) ? RX_PARITY : RX_DATA;
`else
          rx_state_nxt = (rx_bit_r == LAST_BIT) ? RX_STOP : RX_DATA;
`endif
        end else begin
          rx_state_nxt = RX_DATA;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_sample_s) begin
          rx_par_bad_nxt = rx_line_s ^ parity_bit(rx_shift_r, parity_odd);
          rx_state_nxt   = RX_STOP;
        end else begin
          rx_state_nxt = RX_PARITY;
        end
      end
`endif
      RX_STOP: begin
        if (rx_sample_s && rx_line_s) begin
          rx_data_nxt  = rx_shift_r;
          rx_valid_nxt = 1'b1;
`ifdef UART_PARITY_EN
          rx_parity_err_nxt = rx_par_bad_r;
`endif
          rx_state_nxt = RX_IDLE;
        end else if (rx_sample_s) begin
          rx_frame_err_nxt = 1'b1;
          rx_state_nxt     = RX_BREAK;
        end else begin
          rx_state_nxt = RX_STOP;
        end
      end
      RX_BREAK: begin
        if (tick_s && rx_line_s) begin
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_state_nxt = RX_BREAK;
        end
      end
      default: begin
        rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // RX state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r      <= RX_IDLE;
      rx_tick_r       <= ZERO_TICK;
      rx_bit_r        <= 4'd0;
      rx_shift_r      <= {DATA_W{1'b0}};
      rx_data_r       <= {DATA_W{1'b0}};
      rx_valid_r      <= 1'b0;
      rx_frame_err_r  <= 1'b0;
      rx_parity_err_r <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_r    <= 1'b0;
`endif
    end else begin
      rx_state_r      <= rx_state_nxt;
      rx_tick_r       <= rx_tick_nxt;
      rx_bit_r        <= rx_bit_nxt;
      rx_shift_r      <= rx_shift_nxt;
      rx_data_r       <= rx_data_nxt;
      rx_valid_r      <= rx_valid_nxt;
      rx_frame_err_r  <= rx_frame_err_nxt;
      rx_parity_err_r <= rx_parity_err_nxt;
`ifdef UART_PARITY_EN
      rx_par_bad_r    <= rx_par_bad_nxt;
`endif
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_valid      = rx_valid_r;
  assign rx_frame_err  = rx_frame_err_r;
  assign rx_parity_err = rx_parity_err_r;

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: an expected-result queue is filled when frames are issued and a monitor drains it on RX pulses.
// Parity cases are compiled in when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_param;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   divisor;
  logic          stop2;
  logic          parity_odd;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          serial_out;
  logic          serial_in_w;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          drv;
  logic          loop;

  typedef struct packed {
    logic          v;
    logic          fe;
    logic          pe;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ev_cnt = 0;
  int   cyc = 0;
  logic samp [0:640];
  logic rdy  [0:640];

  always #5 clk = ~clk;

  assign serial_in_w = loop ? serial_out : drv;

  uart_param #(.DATA_W(DW), .OVS(16), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .stop2(stop2),
    .parity_odd(parity_odd), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .serial_out(serial_out), .serial_in(serial_in_w),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Posedges since reset release; with a fixed divisor this tracks the tick phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Monitor: every RX pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (rx_valid || rx_frame_err)) begin
      ev_cnt++;
      if (exp_q.size() == 0) begin
        chk("rx_unexpected_event", {30'd0, rx_valid, rx_frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_valid", rx_valid, e.v);
        chk("rx_frame_err", rx_frame_err, e.fe);
        chk("rx_parity_err", rx_parity_err, e.pe);
        chk("rx_data", rx_data, e.d);
      end
    end
  end

  task automatic push_exp(input logic v, input logic fe, input logic pe, input logic [DW-1:0] d);
    exp_t e;
    e.v = v; e.fe = fe; e.pe = pe; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit expect_rx);
    int n = 0;
    while (!tx_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (expect_rx) push_exp(1'b1, 1'b0, 1'b0, d);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_frame(input logic [DW-1:0] d, input logic par, input logic stop_bit);
    int bit_cyc;
    bit_cyc = 16 * (int'(divisor) + 1);
    drv = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      drv = d[i];
      repeat (bit_cyc) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    drv = par;
    repeat (bit_cyc) @(negedge clk);
`else
    if (par) drv = 1'b0;
`endif
    drv = stop_bit;
    repeat (bit_cyc) @(negedge clk);
    drv = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int ev0;
    int n;
    rst_n = 1'b0; divisor = 16'd3; stop2 = 1'b0; parity_odd = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; drv = 1'b1; loop = 1'b0;
    repeat (200) @(negedge clk);
    chk("rst_serial_out", serial_out, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_frame_err", rx_frame_err, 1'b0);
    chk("rst_rx_parity_err", rx_parity_err, 1'b0);
    rst_n = 1'b1;

    // TX timing of 0x8E: handshake placed on a tick edge so every bit is exactly 64 cycles
    n = 0;
    while (!(tx_ready && ((cyc + 1) % 4 == 0)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tx_data = 8'h8E; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= 640; i++) begin
      samp[i] = serial_out;
      rdy[i]  = tx_ready;
      if (i < 640) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    // Parity bit of 0x8E (even) occupies slot 9; stop moves to slot 10, beyond this window
    frame = {1'b0, 8'h8E, 1'b0};
`else
    frame = {1'b1, 8'h8E, 1'b0};
`endif
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("tx_bit%0d_first", b), samp[b * 64], frame[b]);
      chk($sformatf("tx_bit%0d_last", b), samp[b * 64 + 63], frame[b]);
    end
    chk("tx_ready_busy", rdy[0], 1'b0);
`ifndef UART_PARITY_EN
    chk("tx_ready_end_stop", rdy[639], 1'b0);
    chk("tx_ready_after_stop", rdy[640], 1'b1);
`endif

    // Loopback, three frames back to back
    loop = 1'b1;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b1);
    wait_drain(5000);

    // Short low glitch must be rejected silently
    loop = 1'b0; drv = 1'b1;
    repeat (200) @(negedge clk);
    ev0 = ev_cnt;
    drv = 1'b0;
    repeat (20) @(negedge clk);
    drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_event", ev_cnt, ev0);

    // Frame error on 0x55 keeps last data, then a good frame is received
    push_exp(1'b0, 1'b1, 1'b0, 8'hA5);
    drive_frame(8'h55, 1'b0, 1'b0);
    repeat (128) @(negedge clk);
    push_exp(1'b1, 1'b0, 1'b0, 8'h3C);
    drive_frame(8'h3C, 1'b0, 1'b1);
    wait_drain(2000);

    // divisor 0 (tick every cycle) with two stop bits
    divisor = 16'd0; stop2 = 1'b1; loop = 1'b1;
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);
    wait_drain(2000);
    repeat (100) @(negedge clk);
    loop = 1'b0; stop2 = 1'b0; divisor = 16'd3;
    repeat (20) @(negedge clk);

`ifdef UART_PARITY_EN
    parity_odd = 1'b0;
    push_exp(1'b1, 1'b0, 1'b1, 8'h8E);
    drive_frame(8'h8E, 1'b1, 1'b1);
    repeat (64) @(negedge clk);
    push_exp(1'b1, 1'b0, 1'b0, 8'h8E);
    drive_frame(8'h8E, 1'b0, 1'b1);
    wait_drain(2000);
`endif

    // Reset in the middle of a looped-back frame
    ev0 = ev_cnt;
    loop = 1'b1;
    send(8'h0F, 1'b0);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_serial_out", serial_out, 1'b1);
    chk("midrst_tx_ready", tx_ready, 1'b1);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_rx_frame_err", rx_frame_err, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    chk("midrst_no_event", ev_cnt, ev0);
    chk("midrst_line_idle", serial_out, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
